fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mips_pkg.sv | 23 ++
 rtl/fetch_unit_if.sv | 39 +++
 rtl/fetch_buffer.sv | 41 ++++
 rtl/fetch_unit.sv | 117 +++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch front end: data widths,
// the default reset vector, the fetch FSM state type and a PC helper.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // REQ: request outstanding, HOLD: output buffer full,
  // DISCARD: the outstanding request is on the wrong path.
  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  // Instruction fetches are word aligned; low address bits are forced to zero.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's memory, redirect and instruction-output signals.
// master = fetch unit side, slave = memory/datapath side.
interface fetch_unit_if;
  import mips_pkg::*;

  // instruction memory
  logic                imem_req;
  logic [ADDR_W-1:0]   imem_addr;
  logic                imem_ack;
  logic [INSTR_W-1:0]  imem_rdata;

  // redirect from the datapath
  logic                redirect_valid;
  logic [ADDR_W-1:0]   redirect_pc;

  // fetched instruction towards the datapath
  logic                out_valid;
  logic                out_ready;
  logic [INSTR_W-1:0]  out_instr;
  logic [ADDR_W-1:0]   out_pc;
  logic [ADDR_W-1:0]   out_pc4;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect_valid, redirect_pc,
    output out_valid, out_instr, out_pc, out_pc4,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect_valid, redirect_pc,
    input  out_valid, out_instr, out_pc, out_pc4,
    output out_ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// One-entry output buffer: captures an instruction with its pc/pc4 on load,
// drops the valid flag on clear, otherwise holds. Data fields change only on load.
module fetch_buffer
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic [ADDR_W-1:0]  in_pc4,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc4
);

  // Valid flag: set on load, dropped on clear (load wins; they never coincide).
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        valid <= 1'b0;
    else if (load)  valid <= 1'b1;
    else if (clear) valid <= 1'b0;
  end

  // Payload: captured only on load so it stays stable under backpressure.
  // NOTE: the payload is reset too, because the outputs must read zero during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= '0;
      pc    <= '0;
      pc4   <= '0;
    end else if (load) begin
      instr <= in_instr;
      pc    <= in_pc;
      pc4   <= in_pc4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with one outstanding memory request, a
// one-entry output buffer and branch/jump redirect handling.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] pc;          // next address to fetch after the current request
  logic [ADDR_W-1:0] req_addr;    // address of the outstanding request
  logic              first_cycle; // masks a stale ack from a request abandoned by reset

  logic              ack;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic [ADDR_W-1:0] next_addr;
  logic              req_on;
  logic              buf_load;
  logic              buf_clear;

  assign ack           = bus.imem_ack & ~first_cycle;
  assign redirect      = bus.redirect_valid;
  assign redirect_addr = align_word(bus.redirect_pc);
  assign next_addr     = req_addr + STEP;  // wraps modulo 2^32

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_REQ;
    else     state <= state_next;
  end

  // Next-state logic; a redirect always wins over a consumer handshake.
  // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      ST_REQ: begin
        if (redirect && !ack)      state_next = ST_DISCARD;
        else if (!redirect && ack) state_next = ST_HOLD;
      end
      ST_DISCARD: begin
        if (ack) state_next = ST_REQ;
      end
      ST_HOLD: begin
        if (redirect || bus.out_ready) state_next = ST_REQ;
      end
      default: state_next = ST_REQ;
    endcase
  end

  // FSM outputs: memory request and buffer control.
  always_comb begin
    req_on    = (state != ST_HOLD) && !rst;
    buf_load  = (state == ST_REQ) && ack && !redirect;
    buf_clear = (state == ST_HOLD) && (redirect || bus.out_ready);
  end

  // PC and request-address registers; first_cycle drops after one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      first_cycle <= 1'b1;
    end else begin
      first_cycle <= 1'b0;
      case (state)
        ST_REQ: begin
          if (redirect) begin
            pc <= redirect_addr;
            if (ack) req_addr <= redirect_addr;   // returned word is wrong-path
          end else if (ack) begin
            pc <= next_addr;
          end
        end
        ST_DISCARD: begin
          if (redirect) pc <= redirect_addr;      // latest redirect wins
          if (ack)      req_addr <= redirect ? redirect_addr : pc;
        end
        ST_HOLD: begin
          if (redirect) begin
            pc       <= redirect_addr;
            req_addr <= redirect_addr;
          end else if (bus.out_ready) begin
            req_addr <= pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_req  = req_on;
  assign bus.imem_addr = req_addr;

  fetch_buffer u_buffer (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load),
    .clear    (buf_clear),
    .in_instr (bus.imem_rdata),
    .in_pc    (req_addr),
    .in_pc4   (next_addr),
    .valid    (bus.out_valid),
    .instr    (bus.out_instr),
    .pc       (bus.out_pc),
    .pc4      (bus.out_pc4)
  );

endmodule
